// File: rtl/pipeline.sv
// ---------------------------------------------------------------------------
// pipeline -- 2-entry elastic (skid) buffer with a valid/ready handshake on
// each side.
//
// A head register drives the output and a skid register holds the second
// entry. Input ready depends only on the registered occupancy count, so
// there is no combinational path from data_out_ready_i to data_in_ready_o.
// Latency is one cycle. Throughput is one payload per cycle while the
// downstream is ready.
//
// Parameters
//   DW               payload width in bits (DW >= 1)
//
// Ports
//   clk_i            clock; all state changes on its rising edge
//   arst_ni          asynchronous active-low reset; flushes all entries
//   clear_i          synchronous flush; overrides both handshakes
//   data_in_i        upstream payload
//   data_in_valid_i  upstream payload valid
//   data_in_ready_o  buffer can accept a payload (count < 2)
//   data_out_o       oldest held payload
//   data_out_valid_o buffer holds at least one payload
//   data_out_ready_i downstream can accept a payload
//
// Build options
//   PIPELINE_ASSERTIONS_EN  when defined, compiles in simulation checks:
//                           count bound, output stability while stalled,
//                           and no X on data_in_i while it is valid.
// ---------------------------------------------------------------------------
module pipeline #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          clear_i,
    input  logic [DW-1:0] data_in_i,
    input  logic          data_in_valid_i,
    output logic          data_in_ready_o,
    output logic [DW-1:0] data_out_o,
    output logic          data_out_valid_o,
    input  logic          data_out_ready_i
);

    logic [1:0]    count_q;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;

    logic in_fire;
    logic out_fire;

    // Both flags come straight from the count register.
    assign data_in_ready_o  = (count_q != 2'd2);
    assign data_out_valid_o = (count_q != 2'd0);
    assign data_out_o       = head_q;

    assign in_fire  = data_in_valid_i  & data_in_ready_o;
    assign out_fire = data_out_valid_o & data_out_ready_i;

    // NOTE: sequential state uses non-blocking assignments only. Each
    // register then samples the pre-edge value of every other register,
    // which the head/skid shift relies on.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q <= 2'd0;
            // NOTE: the payload registers are reset as well, so that
            // data_out_o reads 0 during and right after reset rather
            // than X.
            head_q  <= '0;
            skid_q  <= '0;
        end else if (clear_i) begin
            // A flush beats any handshake. The offered payload is dropped
            // and the payload registers keep their contents.
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (in_fire) begin
                        head_q  <= data_in_i;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    unique case ({in_fire, out_fire})
                        2'b10: begin
                            // The head is stalled, so the new payload skids.
                            skid_q  <= data_in_i;
                            count_q <= 2'd2;
                        end
                        2'b01: begin
                            count_q <= 2'd0;
                        end
                        2'b11: begin
                            // The head leaves and the new payload takes its place.
                            head_q <= data_in_i;
                        end
                        default: begin
                        end
                    endcase
                end
                2'd2: begin
                    // Input ready is low at count 2, so only the output
                    // side can move. The skid entry becomes the head.
                    if (out_fire) begin
                        head_q  <= skid_q;
                        count_q <= 2'd1;
                    end
                end
                default: begin
                    count_q <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPELINE_ASSERTIONS_EN
    a_count_bound : assert property (
        @(posedge clk_i) disable iff (!arst_ni)
        count_q <= 2'd2
    ) else $error("pipeline: count exceeded 2 (count=%0d)", count_q);

    // A stalled output must hold its value unless a flush removes it.
    a_stall_stable : assert property (
        @(posedge clk_i) disable iff (!arst_ni)
        (data_out_valid_o && !data_out_ready_i && !clear_i)
            |=> (data_out_valid_o && $stable(data_out_o))
    ) else $error("pipeline: output changed while stalled");

    a_no_x_input : assert property (
        @(posedge clk_i) disable iff (!arst_ni)
        data_in_valid_i |-> !$isunknown(data_in_i)
    ) else $error("pipeline: data_in_i is X while data_in_valid_i=1");
`endif

endmodule

// File: tb/tb_pipeline.sv
// ---------------------------------------------------------------------------
// tb_pipeline -- self-checking bench for pipeline.
//
// Instance u_dut8 (DW=8) runs the directed scenarios with hand-computed
// expected values: reset, streaming, backpressure, clear and a reset in the
// middle of operation.
// Instance u_dut32 (DW=32) runs a random valid/ready stream. A queue model
// holds the expected payload order.
// ---------------------------------------------------------------------------
module tb_pipeline;

    logic clk;
    logic rst_n;

    // 8-bit instance
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // 32-bit instance
    logic [31:0] r_in_data;
    logic        r_in_valid;
    logic        r_in_ready;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_ready;

    int vectors     = 0;
    int miscompares = 0;

    pipeline #(.DW(8)) u_dut8 (
        .clk_i            (clk),
        .arst_ni          (rst_n),
        .clear_i          (clear),
        .data_in_i        (in_data),
        .data_in_valid_i  (in_valid),
        .data_in_ready_o  (in_ready),
        .data_out_o       (out_data),
        .data_out_valid_o (out_valid),
        .data_out_ready_i (out_ready)
    );

    pipeline #(.DW(32)) u_dut32 (
        .clk_i            (clk),
        .arst_ni          (rst_n),
        .clear_i          (1'b0),
        .data_in_i        (r_in_data),
        .data_in_valid_i  (r_in_valid),
        .data_in_ready_o  (r_in_ready),
        .data_out_o       (r_out_data),
        .data_out_valid_o (r_out_valid),
        .data_out_ready_i (r_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where inputs are driven
    // and outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out8(input string tag, input logic v, input logic [7:0] d, input logic r);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, r});
    endtask

    logic [31:0] exp_q[$];
    logic        prev_stall;
    logic [31:0] prev_data;

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        r_in_data   = '0;
        r_in_valid  = 1'b0;
        r_out_ready = 1'b0;

        // ---- reset then idle ----
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {24'd0, out_data},  32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd1);
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        check_out8("idle", 1'b0, 8'h00, 1'b1);
        check("idle_data", {24'd0, out_data}, 32'd0);

        // ---- streaming: each payload appears one edge after acceptance ----
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11; step(); check_out8("str0", 1'b1, 8'h11, 1'b1);
        in_data   = 8'h22; step(); check_out8("str1", 1'b1, 8'h22, 1'b1);
        in_data   = 8'h33; step(); check_out8("str2", 1'b1, 8'h33, 1'b1);
        in_valid  = 1'b0;  step(); check_out8("str_end", 1'b0, 8'h00, 1'b1);

        // ---- backpressure ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1; step(); check_out8("bp0", 1'b1, 8'hA1, 1'b1);
        in_data   = 8'hA2; step(); check_out8("bp1", 1'b1, 8'hA1, 1'b0);
        in_data   = 8'hA3; step(); check_out8("bp_full", 1'b1, 8'hA1, 1'b0);
        step();                    check_out8("bp_hold", 1'b1, 8'hA1, 1'b0);
        out_ready = 1'b1;          // A3 is still offered; ready is 0 before this edge
        step();                    check_out8("bp_drain0", 1'b1, 8'hA2, 1'b1);
        step();                    check_out8("bp_drain1", 1'b1, 8'hA3, 1'b1);
        in_valid  = 1'b0;
        step();                    check_out8("bp_empty", 1'b0, 8'h00, 1'b1);

        // ---- clear with two entries held ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A; step();
        in_data   = 8'h5B; step(); check_out8("clr_full", 1'b1, 8'h5A, 1'b0);
        clear     = 1'b1;
        in_data   = 8'h5C; step(); check_out8("clr0", 1'b0, 8'h00, 1'b1);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;  step(); check_out8("clr0_after", 1'b0, 8'h00, 1'b1);

        // ---- clear beats a concurrent input and output handshake at count 1 ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A; step(); check_out8("clr1_one", 1'b1, 8'h5A, 1'b1);
        out_ready = 1'b1;
        clear     = 1'b1;
        in_data   = 8'h5C; step(); check_out8("clr1", 1'b0, 8'h00, 1'b1);
        clear     = 1'b0;
        in_valid  = 1'b0;  step(); check_out8("clr1_after", 1'b0, 8'h00, 1'b1);

        // ---- reset in the middle of operation with two entries held ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC1; step();
        in_data   = 8'hC2; step(); check_out8("mrst_full", 1'b1, 8'hC1, 1'b0);
        in_valid  = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_data",  {24'd0, out_data},  32'd0);
        check("mrst_ready", {31'd0, in_ready},  32'd1);
        step();
        #2 rst_n  = 1'b1;
        step();
        check_out8("mrst_after", 1'b0, 8'h00, 1'b1);

        // ---- random valid/ready on the 32-bit instance ----
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 10000; i++) begin
            r_in_valid  = 1'($urandom_range(0, 1));
            r_in_data   = $urandom;
            r_out_ready = 1'($urandom_range(0, 1));
            check("rnd_valid", {31'd0, r_out_valid}, {31'd0, exp_q.size() != 0});
            check("rnd_ready", {31'd0, r_in_ready},  {31'd0, exp_q.size() < 2});
            if (prev_stall) check("rnd_stall", r_out_data, prev_data);
            if (r_out_valid && r_out_ready && exp_q.size() > 0)
                check("rnd_order", r_out_data, exp_q.pop_front());
            if (r_in_valid && r_in_ready)
                exp_q.push_back(r_in_data);
            prev_stall = r_out_valid && !r_out_ready;
            prev_data  = r_out_data;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
